// File: rtl/ad9228_pkg.sv
// ad9228_pkg: constants shared by the AD9228 emulation transmitter and the
// channel receive side.
//   AD9228_DATA_WIDTH : default sample width / bits per frame
//   AD9228_FCO_HIGH   : number of leading bits of a frame with FCO high
//   ST_IDLE / ST_RUN  : framing state encoding
//   fco_high_bits()   : FCO high-half length for an arbitrary even width
package ad9228_pkg;

  localparam int AD9228_DATA_WIDTH = 12;
  localparam int AD9228_FCO_HIGH   = AD9228_DATA_WIDTH / 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int fco_high_bits(input int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/ad9228_tx_serializer.sv
// ad9228_tx_serializer: frame engine of the AD9228 emulation transmitter.
// Owns the shift register, bit counter and FCO/DCO/frame_start generation,
// and tells the top when a new word is taken (load_o).
// Ports:
//   clk, rstn        : bit clock, async active-low reset
//   enable_i         : start/stop framing (frames are never truncated)
//   word_i           : word sampled into the shift register on load_o
//   load_o           : combinational load strobe (IDLE->RUN or last bit)
//   dout_o           : serial data, MSB first
//   fco_o, dco_o     : frame clock, data clock
//   frame_start_o    : pulse on bit 0 of each frame
module ad9228_tx_serializer
  import ad9228_pkg::*;
#(
  parameter int DATA_WIDTH = AD9228_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic                  load_o,
  output logic                  dout_o,
  output logic                  fco_o,
  output logic                  dco_o,
  output logic                  frame_start_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] FCO_HI = BW'(fco_high_bits(DATA_WIDTH));

  logic [0:0]            state_q, state_d;
  logic [BW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  fco_q, fco_d;
  logic                  dco_q, dco_d;
  logic                  fs_q, fs_d;

  // A new frame starts either from IDLE or back-to-back after the last bit;
  // with enable low at the last bit the engine drops to IDLE instead.
  assign load_o  = enable_i && ((state_q == ST_IDLE) || (cnt_q == LAST));
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    fco_d   = fco_q;
    dco_d   = dco_q;
    fs_d    = 1'b0;
    if (load_o) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      sh_d    = word_i;
      fco_d   = 1'b1;
      dco_d   = 1'b1;
      fs_d    = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == LAST) begin
        // Shift register is cleared so dout reads 0 throughout IDLE.
        state_d = ST_IDLE;
        cnt_d   = '0;
        sh_d    = '0;
        fco_d   = 1'b0;
        dco_d   = 1'b0;
      end else begin
        cnt_d   = cnt_inc;
        sh_d    = {sh_q[DATA_WIDTH-2:0], 1'b0};
        fco_d   = (cnt_inc < FCO_HI);
        dco_d   = ~dco_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      fco_q   <= 1'b0;
      dco_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      fco_q   <= fco_d;
      dco_q   <= dco_d;
      fs_q    <= fs_d;
    end
  end

  assign dout_o        = sh_q[DATA_WIDTH-1];
  assign fco_o         = fco_q;
  assign dco_o         = dco_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/ad9228_serial_tx.sv
// ad9228_serial_tx: single-lane AD9228 serial output emulator. Accepts
// parallel samples over valid/ready into a one-entry hold register and
// serialises them MSB first with FCO and DDR DCO (single-ended).
// Optional feature macro: AD9228_TX_TEST_PATTERN_EN (internal ramp source
// selected by pattern_en); without it pattern_en is ignored.
// Ports:
//   clk, rstn            : bit clock, async active-low reset
//   enable               : start/stop framing
//   s_data/s_valid/s_ready : sample input handshake (ready = hold empty)
//   pattern_en           : ramp pattern select (macro builds only)
//   dout, fco, dco       : serial data, frame clock, data clock
//   frame_start          : pulse on bit 0 of each frame
//   underrun_cnt         : saturating count of IDLE_WORD frames
module ad9228_serial_tx
  import ad9228_pkg::*;
#(
  parameter int                    DATA_WIDTH = AD9228_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  pattern_en,
  output logic                  dout,
  output logic                  fco,
  output logic                  dco,
  output logic                  frame_start,
  output logic [CNT_WIDTH-1:0]  underrun_cnt
);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  s_ready_q;
  logic [CNT_WIDTH-1:0]  unr_q, unr_d;
  logic                  load;
  logic                  accept;
  logic                  pat_sel;
  logic [DATA_WIDTH-1:0] word;

`ifdef AD9228_TX_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] ramp_q;

  assign pat_sel = pattern_en;

  // Ramp advances once per pattern frame and wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                ramp_q <= '0;
    else if (load && pat_sel) ramp_q <= ramp_q + 1'b1;
  end

  assign word = pat_sel ? ramp_q : (hold_valid_q ? hold_q : IDLE_WORD);
`else
  logic unused_pattern_en;

  assign unused_pattern_en = pattern_en;
  assign pat_sel           = 1'b0;
  assign word              = hold_valid_q ? hold_q : IDLE_WORD;
`endif

  assign accept = s_valid && s_ready_q;

  // Load sees the pre-accept hold state: an accept on a load cycle with an
  // empty hold still sends IDLE_WORD and the new word waits a frame.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    unr_d        = unr_q;
    if (load && !pat_sel) begin
      if (hold_valid_q)   hold_valid_d = 1'b0;
      else if (~&unr_q)   unr_d        = unr_q + 1'b1;
    end
    if (accept) begin
      hold_d       = s_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
      unr_q        <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      s_ready_q    <= ~hold_valid_d;
      unr_q        <= unr_d;
    end
  end

  ad9228_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk           (clk),
    .rstn          (rstn),
    .enable_i      (enable),
    .word_i        (word),
    .load_o        (load),
    .dout_o        (dout),
    .fco_o         (fco),
    .dco_o         (dco),
    .frame_start_o (frame_start)
  );

  assign s_ready      = s_ready_q;
  assign underrun_cnt = unr_q;

endmodule
